// File: rtl/operand_entry_if.sv
// Key-event handshake between the keypad scanner (master) and the operand
// entry block (slave).
//
// Handshake: the scanner presents an event as a level on read_input
// (digit, with keypad_input), operator_input (non-zero) or equal_input.
// The consumer acknowledges each accepted event with a one-cycle key_read
// pulse on the cycle after it was taken. A new event is only taken once
// all event levels have been low for at least one cycle, so a held level
// is consumed exactly once.
//
// Signals:
//   read_input     scanner -> entry  digit-valid level
//   keypad_input   scanner -> entry  digit value 0-9
//   operator_input scanner -> entry  001 sign, 010 add, 011 sub, 100 mul
//   equal_input    scanner -> entry  equal key
//   key_read       entry -> scanner  one-cycle acknowledge
interface operand_entry_if;
  logic       read_input;
  logic [3:0] keypad_input;
  logic [2:0] operator_input;
  logic       equal_input;
  logic       key_read;

  modport master (
    output read_input,
    output keypad_input,
    output operator_input,
    output equal_input,
    input  key_read
  );

  modport slave (
    input  read_input,
    input  keypad_input,
    input  operator_input,
    input  equal_input,
    output key_read
  );
endinterface

// File: rtl/operand_entry.sv
// Operand entry: consumes keypad events, builds two signed 16-bit operands
// and an operator code, then pulses calc_start towards the arithmetic unit.
//
// Ports:
//   clk          system clock
//   nRST         asynchronous active-low reset
//   key          key-event handshake (slave side)
//   operand_a    signed first operand, latched on the operator key
//   operand_b    signed second operand, latched on the equal key
//   op_code      latched operator (010 add, 011 sub, 100 mul)
//   calc_start   one-cycle pulse when both operands are valid
//   entry_value  signed operand currently being typed
//   overflow     sticky: a digit was rejected for range or digit count
//   entry_state  current FSM state (0 ENTER_A, 1 ENTER_B, 2 DONE)
module operand_entry #(
  parameter int MAX_DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  nRST,
  operand_entry_if.slave        key,
  output logic [15:0]           operand_a,
  output logic [15:0]           operand_b,
  output logic [2:0]            op_code,
  output logic                  calc_start,
  output logic [15:0]           entry_value,
  output logic                  overflow,
  output logic [1:0]            entry_state
);

  localparam int            CW      = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t        state;
  logic          armed;
  logic [16:0]   mag;
  logic          neg;
  logic [CW-1:0] cnt;

  logic        ev;
  logic        ev_eq;
  logic        ev_op;
  logic        ev_dig;
  logic        is_sign;
  logic        is_arith;
  logic        dig_valid;
  logic        dig_ok;
  logic        cnt_zero;
  logic [19:0] cand;
  logic [19:0] limit;
  logic [16:0] mag_neg;

  // Event classes are mutually exclusive: equal > operator > digit.
  assign ev      = key.read_input | (key.operator_input != 3'b000) | key.equal_input;
  assign ev_eq   = key.equal_input;
  assign ev_op   = !key.equal_input && (key.operator_input != 3'b000);
  assign ev_dig  = !key.equal_input && (key.operator_input == 3'b000) && key.read_input;

  assign is_sign   = (key.operator_input == 3'b001);
  assign is_arith  = (key.operator_input == 3'b010) || (key.operator_input == 3'b011) ||
                     (key.operator_input == 3'b100);
  assign dig_valid = (key.keypad_input <= 4'd9);
  assign cnt_zero  = (cnt == '0);

  // Magnitude is kept unsigned so -32768 fits; the limit widens by one
  // when the operand is negative.
  assign cand   = {3'b000, mag} * 20'd10 + {16'h0000, key.keypad_input};
  assign limit  = neg ? 20'd32768 : 20'd32767;
  assign dig_ok = dig_valid && (cnt < MAX_CNT) && (cand <= limit);

  assign mag_neg     = -mag;
  assign entry_value = neg ? mag_neg[15:0] : mag[15:0];
  assign entry_state = state;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state        <= ENTER_A;
      armed        <= 1'b1;
      mag          <= '0;
      neg          <= 1'b0;
      cnt          <= '0;
      key.key_read <= 1'b0;
      calc_start   <= 1'b0;
      overflow     <= 1'b0;
      operand_a    <= '0;
      operand_b    <= '0;
      op_code      <= '0;
    end else begin
      key.key_read <= 1'b0;
      calc_start   <= 1'b0;
      if (!ev) begin
        armed <= 1'b1;
      end else if (armed) begin
        armed        <= 1'b0;
        key.key_read <= 1'b1;
        case (state)
          ENTER_A, ENTER_B: begin
            if (ev_dig) begin
              if (dig_ok) begin
                mag <= cand[16:0];
                cnt <= cnt + CW'(1);
              end else if (dig_valid) begin
                overflow <= 1'b1;
              end
            end else if (ev_op && is_sign) begin
              if (cnt_zero) neg <= ~neg;
            end else if (ev_op && is_arith) begin
              if (state == ENTER_A) begin
                if (!cnt_zero) begin
                  operand_a <= entry_value;
                  op_code   <= key.operator_input;
                  mag       <= '0;
                  neg       <= 1'b0;
                  cnt       <= '0;
                  overflow  <= 1'b0;
                  state     <= ENTER_B;
                end
              end else if (cnt_zero) begin
                // No B digits yet: the operator key corrects the choice.
                op_code <= key.operator_input;
              end
            end else if (ev_eq && (state == ENTER_B) && !cnt_zero) begin
              operand_b  <= entry_value;
              calc_start <= 1'b1;
              state      <= DONE;
            end
          end
          DONE: begin
            // A digit or sign after a result starts a fresh operand A.
            if (ev_dig && dig_valid) begin
              mag      <= {13'd0, key.keypad_input};
              cnt      <= CW'(1);
              neg      <= 1'b0;
              overflow <= 1'b0;
              state    <= ENTER_A;
            end else if (ev_op && is_sign) begin
              mag      <= '0;
              cnt      <= '0;
              neg      <= 1'b1;
              overflow <= 1'b0;
              state    <= ENTER_A;
            end
          end
          default: state <= ENTER_A;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_operand_entry.sv
module tb_operand_entry;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic [2:0]  op_code;
  logic        calc_start;
  logic [15:0] entry_value;
  logic        overflow;
  logic [1:0]  entry_state;

  operand_entry_if kif ();

  operand_entry #(.MAX_DIGITS(5)) dut (
    .clk         (clk),
    .nRST        (nRST),
    .key         (kif),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .op_code     (op_code),
    .calc_start  (calc_start),
    .entry_value (entry_value),
    .overflow    (overflow),
    .entry_state (entry_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int kr_pulses;
  int cs_pulses;
  int tot_kr;
  int tot_cs;

  logic [34:0] exp_q[$];
  logic [34:0] got_q[$];

  // ---------------- reference model ----------------
  int          m_mag;
  int          m_cnt;
  bit          m_neg;
  bit          m_ovf;
  int          m_phase;   // 0 typing A, 1 typing B, 2 result shown
  logic [15:0] m_a;
  logic [15:0] m_b;
  logic [2:0]  m_op;

  function automatic logic [15:0] m_entry();
    int v;
    v = m_neg ? -m_mag : m_mag;
    return v[15:0];
  endfunction

  task automatic model_clear();
    m_mag = 0; m_neg = 0; m_cnt = 0; m_ovf = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_phase = 0; m_a = '0; m_b = '0; m_op = '0;
  endtask

  task automatic model_digit(input int d);
    int lim;
    lim = m_neg ? 32768 : 32767;
    if (m_cnt < 5 && m_mag * 10 + d <= lim) begin
      m_mag = m_mag * 10 + d;
      m_cnt = m_cnt + 1;
    end else begin
      m_ovf = 1;
    end
  endtask

  task automatic model_event(input logic rd, input logic [3:0] k, input logic [2:0] op,
                             input logic eq, output bit cs);
    cs = 0;
    if (!(rd || op != 3'b000 || eq)) return;
    if (eq) begin
      if (m_phase == 1 && m_cnt > 0) begin
        m_b = m_entry(); m_phase = 2; cs = 1;
      end
    end else if (op != 3'b000) begin
      if (op == 3'b001) begin
        if (m_phase == 2) begin
          model_clear(); m_neg = 1; m_phase = 0;
        end else if (m_cnt == 0) begin
          m_neg = !m_neg;
        end
      end else if (op <= 3'b100) begin
        if (m_phase == 0 && m_cnt > 0) begin
          m_a = m_entry(); m_op = op; model_clear(); m_phase = 1;
        end else if (m_phase == 1 && m_cnt == 0) begin
          m_op = op;
        end
      end
    end else begin
      if (m_phase == 2) begin
        model_clear(); m_phase = 0;
      end
      model_digit(int'(k));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    kif.read_input = 1'b0; kif.keypad_input = 4'd0;
    kif.operator_input = 3'b000; kif.equal_input = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nRST = 1'b0;
    clear_inputs();
    @(negedge clk);
    nRST = 1'b1;
    model_reset();
  endtask

  // One key press: event level for one cycle, then one idle cycle.
  task automatic press(input logic rd, input logic [3:0] k, input logic [2:0] op,
                       input logic eq, output bit exp_cs);
    @(negedge clk);
    kif.read_input = rd; kif.keypad_input = k;
    kif.operator_input = op; kif.equal_input = eq;
    model_event(rd, k, op, eq, exp_cs);
    if (exp_cs) exp_q.push_back({m_a, m_b, m_op});
    kr_pulses = 0; cs_pulses = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      kr_pulses += int'(kif.key_read);
      cs_pulses += int'(calc_start);
      if (calc_start) got_q.push_back({operand_a, operand_b, op_code});
      clear_inputs();
    end
    tot_kr += kr_pulses;
    tot_cs += cs_pulses;
  endtask

  task automatic key_digit(input int d);
    bit cs;
    press(1'b1, 4'(d), 3'b000, 1'b0, cs);
  endtask

  task automatic key_op(input logic [2:0] op);
    bit cs;
    press(1'b0, 4'd0, op, 1'b0, cs);
  endtask

  task automatic key_eq();
    bit cs;
    press(1'b0, 4'd0, 3'b000, 1'b1, cs);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    nRST = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (kif.key_read !== 1'b0) begin n_errors++; $display("FAIL reset_key_read got %b exp 0", kif.key_read); end
    n_checks++; if (calc_start !== 1'b0) begin n_errors++; $display("FAIL reset_calc_start got %b exp 0", calc_start); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    n_checks++; if (operand_a !== 16'd0) begin n_errors++; $display("FAIL reset_operand_a got %h exp 0", operand_a); end
    n_checks++; if (operand_b !== 16'd0) begin n_errors++; $display("FAIL reset_operand_b got %h exp 0", operand_b); end
    n_checks++; if (op_code !== 3'b000) begin n_errors++; $display("FAIL reset_op_code got %b exp 000", op_code); end
    n_checks++; if (entry_value !== 16'd0) begin n_errors++; $display("FAIL reset_entry_value got %h exp 0", entry_value); end
    n_checks++; if (entry_state !== 2'd0) begin n_errors++; $display("FAIL reset_state got %0d exp 0", entry_state); end
    @(negedge clk);
    nRST = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    exp_q.delete(); got_q.delete();
    tot_kr = 0; tot_cs = 0;
    key_digit(1); key_digit(2); key_digit(3);
    n_checks++; if (entry_value !== 16'd123) begin n_errors++; $display("FAIL basic_entry got %0d exp 123", entry_value); end
    key_op(3'b010);
    key_digit(4); key_digit(5);
    key_eq();
    n_checks++; if (tot_kr != 7) begin n_errors++; $display("FAIL basic_key_read_count got %0d exp 7", tot_kr); end
    n_checks++; if (operand_a !== 16'd123) begin n_errors++; $display("FAIL basic_operand_a got %0d exp 123", operand_a); end
    n_checks++; if (operand_b !== 16'd45) begin n_errors++; $display("FAIL basic_operand_b got %0d exp 45", operand_b); end
    n_checks++; if (op_code !== 3'b010) begin n_errors++; $display("FAIL basic_op_code got %b exp 010", op_code); end
    n_checks++; if (tot_cs != 1) begin n_errors++; $display("FAIL basic_calc_start_count got %0d exp 1", tot_cs); end
    n_checks++; if (entry_state !== 2'd2) begin n_errors++; $display("FAIL basic_state got %0d exp 2", entry_state); end
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== {16'd123, 16'd45, 3'b010}) begin
      n_errors++; $display("FAIL basic_calc_snapshot got %0d entries exp 1 {123,45,010}", got_q.size());
    end
  endtask

  task automatic test_min_neg();
    exp_q.delete(); got_q.delete();
    key_op(3'b001);
    key_digit(3); key_digit(2); key_digit(7); key_digit(6); key_digit(8);
    n_checks++; if (entry_value !== 16'h8000) begin n_errors++; $display("FAIL minneg_entry got %h exp 8000", entry_value); end
    key_op(3'b100);
    key_digit(2);
    key_eq();
    n_checks++; if (operand_a !== 16'h8000) begin n_errors++; $display("FAIL minneg_operand_a got %h exp 8000", operand_a); end
    n_checks++; if (operand_b !== 16'd2) begin n_errors++; $display("FAIL minneg_operand_b got %h exp 0002", operand_b); end
    n_checks++; if (op_code !== 3'b100) begin n_errors++; $display("FAIL minneg_op_code got %b exp 100", op_code); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL minneg_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_overflow();
    key_digit(3); key_digit(2); key_digit(7); key_digit(6);
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_before got %b exp 0", overflow); end
    key_digit(8);
    n_checks++; if (entry_value !== 16'd3276) begin n_errors++; $display("FAIL ovf_entry got %0d exp 3276", entry_value); end
    n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    key_op(3'b010);
    n_checks++; if (operand_a !== 16'd3276) begin n_errors++; $display("FAIL ovf_operand_a got %0d exp 3276", operand_a); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_cleared got %b exp 0", overflow); end
    n_checks++; if (entry_state !== 2'd1) begin n_errors++; $display("FAIL ovf_state got %0d exp 1", entry_state); end
  endtask

  task automatic test_held();
    int pulses;
    bit cs;
    do_reset();
    pulses = 0;
    @(negedge clk);
    kif.read_input = 1'b1; kif.keypad_input = 4'd7;
    model_event(1'b1, 4'd7, 3'b000, 1'b0, cs);
    repeat (20) begin
      @(negedge clk);
      pulses += int'(kif.key_read);
    end
    clear_inputs();
    @(negedge clk);
    pulses += int'(kif.key_read);
    n_checks++; if (pulses != 1) begin n_errors++; $display("FAIL held_key_read_count got %0d exp 1", pulses); end
    n_checks++; if (entry_value !== 16'd7) begin n_errors++; $display("FAIL held_entry got %0d exp 7", entry_value); end
    key_digit(7);
    n_checks++; if (entry_value !== 16'd77) begin n_errors++; $display("FAIL held_repeat_entry got %0d exp 77", entry_value); end
  endtask

  task automatic test_op_correction();
    do_reset();
    key_digit(5);
    key_op(3'b010);
    key_op(3'b011);
    key_op(3'b100);
    n_checks++; if (op_code !== 3'b100) begin n_errors++; $display("FAIL opfix_op_code got %b exp 100", op_code); end
    tot_kr = 0; tot_cs = 0;
    key_eq();
    n_checks++; if (tot_kr != 1) begin n_errors++; $display("FAIL opfix_eq_key_read got %0d exp 1", tot_kr); end
    n_checks++; if (tot_cs != 0) begin n_errors++; $display("FAIL opfix_eq_calc_start got %0d exp 0", tot_cs); end
    n_checks++; if (entry_state !== 2'd1) begin n_errors++; $display("FAIL opfix_state got %0d exp 1", entry_state); end
    key_digit(6);
    key_op(3'b011);
    n_checks++; if (op_code !== 3'b100) begin n_errors++; $display("FAIL opfix_locked got %b exp 100", op_code); end
  endtask

  task automatic test_reset_mid();
    key_digit(1);
    n_checks++; if (entry_value !== 16'd61) begin n_errors++; $display("FAIL rstmid_entry_before got %0d exp 61", entry_value); end
    #2 nRST = 1'b0;
    #1;
    n_checks++; if (entry_value !== 16'd0) begin n_errors++; $display("FAIL rstmid_entry got %h exp 0", entry_value); end
    n_checks++; if (operand_a !== 16'd0) begin n_errors++; $display("FAIL rstmid_operand_a got %h exp 0", operand_a); end
    n_checks++; if (op_code !== 3'b000) begin n_errors++; $display("FAIL rstmid_op_code got %b exp 000", op_code); end
    n_checks++; if (entry_state !== 2'd0) begin n_errors++; $display("FAIL rstmid_state got %0d exp 0", entry_state); end
    @(negedge clk);
    nRST = 1'b1;
    model_reset();
    key_digit(9);
    n_checks++; if (entry_value !== 16'd9) begin n_errors++; $display("FAIL rstmid_next_digit got %0d exp 9", entry_value); end
    n_checks++; if (entry_state !== 2'd0) begin n_errors++; $display("FAIL rstmid_next_state got %0d exp 0", entry_state); end
  endtask

  task automatic test_random();
    bit          cs;
    int          r;
    logic        rd;
    logic [3:0]  k;
    logic [2:0]  op;
    logic        eq;
    logic [34:0] e;
    logic [34:0] g;
    do_reset();
    exp_q.delete(); got_q.delete();
    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(0, 9);
      rd = 1'b0; k = 4'($urandom_range(0, 9)); op = 3'b000; eq = 1'b0;
      if (r < 6) begin
        rd = 1'b1;
      end else if (r < 9) begin
        op = 3'($urandom_range(1, 4));
        rd = 1'($urandom_range(0, 1));
      end else begin
        eq = 1'b1;
        rd = 1'($urandom_range(0, 1));
        op = 3'($urandom_range(0, 4));
      end
      press(rd, k, op, eq, cs);
      n_checks++; if (kr_pulses != 1) begin n_errors++; $display("FAIL rand_key_read[%0d] got %0d exp 1", n, kr_pulses); end
      n_checks++; if (cs_pulses != int'(cs)) begin n_errors++; $display("FAIL rand_calc_start[%0d] got %0d exp %0d", n, cs_pulses, cs); end
      n_checks++; if (entry_value !== m_entry()) begin n_errors++; $display("FAIL rand_entry[%0d] got %h exp %h", n, entry_value, m_entry()); end
      n_checks++; if (entry_state !== 2'(m_phase)) begin n_errors++; $display("FAIL rand_state[%0d] got %0d exp %0d", n, entry_state, m_phase); end
      n_checks++; if (overflow !== m_ovf) begin n_errors++; $display("FAIL rand_overflow[%0d] got %b exp %b", n, overflow, m_ovf); end
      n_checks++; if (operand_a !== m_a) begin n_errors++; $display("FAIL rand_operand_a[%0d] got %h exp %h", n, operand_a, m_a); end
      n_checks++; if (operand_b !== m_b) begin n_errors++; $display("FAIL rand_operand_b[%0d] got %h exp %h", n, operand_b, m_b); end
      n_checks++; if (op_code !== m_op) begin n_errors++; $display("FAIL rand_op_code[%0d] got %b exp %b", n, op_code, m_op); end
    end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL rand_calc_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++; if (g !== e) begin n_errors++; $display("FAIL rand_calc_snapshot got %h exp %h", g, e); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    tot_kr = 0; tot_cs = 0;
    model_reset();
    test_reset();
    test_basic();
    test_min_neg();
    test_overflow();
    test_held();
    test_op_correction();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    n_errors++;
    $display("FAIL watchdog got timeout exp completion");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
